mem_access_unit: RTL

- MEM-stage data-memory controller sitting directly downstream of the EX/MEM pipeline register.
- Consumes address (ALU result), store data (rs2), rd and memory control bits.
- Drives a single-outstanding req/ack data bus with byte enables, and formats load data (alignment, sign/zero extension) for the MEM/WB register.
- Stalls the pipeline while an access is in flight.

---
 rtl/mem_access_unit.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory controller: single-outstanding req/ack bus, byte lanes, load formatting.
// Optional misaligned-access trap when MEMU_MISALIGN_EN is defined (default: disabled).
module mem_access_unit #(
  parameter int WIDTH          = 32,
  parameter int INDEX          = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               mem_read_in,
  input  logic               mem_write_in,
  input  logic [2:0]         funct3_in,
  input  logic [WIDTH-1:0]   alu_res_in,
  input  logic [WIDTH-1:0]   drs2_in,
  input  logic [INDEX-1:0]   rd_in,
  output logic               dbus_req_out,
  output logic               dbus_we_out,
  output logic [WIDTH-1:0]   dbus_addr_out,
  output logic [WIDTH/8-1:0] dbus_be_out,
  output logic [WIDTH-1:0]   dbus_wdata_out,
  input  logic               dbus_ack_in,
  input  logic [WIDTH-1:0]   dbus_rdata_in,
  output logic               stall_out,
  output logic               load_valid_out,
  output logic [WIDTH-1:0]   load_data_out,
  output logic [INDEX-1:0]   rd_out,
  output logic               err_out
);

  localparam int NB = WIDTH / 8;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [1:0]       lo_reg;
  logic [1:0]       size_reg;
  logic             uns_reg;
  logic             load_reg;
  logic [INDEX-1:0] rd_reg;

  logic             access;
  logic             is_load;
  logic [1:0]       size_in;
  logic [NB-1:0]    be_in;
  logic [WIDTH-1:0] wdata_in;
  logic [WIDTH-1:0] ld_shift;
  logic [WIDTH-1:0] ld_fmt;

  assign access  = mem_read_in | mem_write_in;
  assign is_load = mem_read_in & ~mem_write_in;

  // size code: 0 = byte, 1 = half, 2 = word (any funct3 with bit 1 set is a word)
  assign size_in = funct3_in[1] ? 2'd2 : {1'b0, funct3_in[0]};

  always_comb begin
    case (size_in)
      2'd0:    be_in = 4'b0001 << alu_res_in[1:0];
      2'd1:    be_in = 4'b0011 << {alu_res_in[1], 1'b0};
      default: be_in = 4'b1111;
    endcase
  end

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign wdata_in[8*gi +: 8] = (size_in == 2'd0) ? drs2_in[7:0] :
                                 (size_in == 2'd1) ? drs2_in[8*(gi%2) +: 8] :
                                                     drs2_in[8*gi +: 8];
  end

  assign ld_shift = (size_reg == 2'd1) ? (dbus_rdata_in >> {lo_reg[1], 4'b0000})
                                       : (dbus_rdata_in >> {lo_reg, 3'b000});

  always_comb begin
    case (size_reg)
      2'd0:    ld_fmt = {{(WIDTH-8){~uns_reg & ld_shift[7]}}, ld_shift[7:0]};
      2'd1:    ld_fmt = {{(WIDTH-16){~uns_reg & ld_shift[15]}}, ld_shift[15:0]};
      default: ld_fmt = dbus_rdata_in;
    endcase
  end

`ifdef MEMU_MISALIGN_EN
  logic misaligned;
  assign misaligned = ((size_in == 2'd1) && alu_res_in[0]) ||
                      ((size_in == 2'd2) && (alu_res_in[1:0] != 2'b00));
`endif

  // Reset is folded in so the stall releases together with the asynchronous clear.
  always_comb begin
    stall_out = 1'b0;
    if (!rst_in) begin
      case (state_reg)
        IDLE:    stall_out = access;
        REQ:     stall_out = 1'b1;
        default: stall_out = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      lo_reg         <= '0;
      size_reg       <= '0;
      uns_reg        <= 1'b0;
      load_reg       <= 1'b0;
      rd_reg         <= '0;
      dbus_req_out   <= 1'b0;
      dbus_we_out    <= 1'b0;
      dbus_addr_out  <= '0;
      dbus_be_out    <= '0;
      dbus_wdata_out <= '0;
      load_valid_out <= 1'b0;
      load_data_out  <= '0;
      rd_out         <= '0;
      err_out        <= 1'b0;
    end else begin
      load_valid_out <= 1'b0;
      err_out        <= 1'b0;
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (access) begin
            lo_reg         <= alu_res_in[1:0];
            size_reg       <= size_in;
            uns_reg        <= funct3_in[2];
            load_reg       <= is_load;
            rd_reg         <= rd_in;
            dbus_we_out    <= mem_write_in;
            dbus_addr_out  <= {alu_res_in[WIDTH-1:2], 2'b00};
            dbus_be_out    <= be_in;
            dbus_wdata_out <= wdata_in;
`ifdef MEMU_MISALIGN_EN
            if (misaligned) begin
              state_reg      <= DONE;
              err_out        <= 1'b1;
              rd_out         <= rd_in;
              load_valid_out <= is_load;
              if (is_load) load_data_out <= '0;
            end else
`endif
            begin
              dbus_req_out <= 1'b1;
              state_reg    <= REQ;
            end
          end
        end
        REQ: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (dbus_ack_in) begin
            dbus_req_out <= 1'b0;
            state_reg    <= DONE;
            rd_out       <= rd_reg;
            if (load_reg) begin
              load_data_out  <= ld_fmt;
              load_valid_out <= 1'b1;
            end
          end else if (cnt_reg == CNT_LAST) begin
            dbus_req_out <= 1'b0;
            state_reg    <= DONE;
            err_out      <= 1'b1;
            rd_out       <= rd_reg;
            if (load_reg) begin
              load_data_out  <= '0;
              load_valid_out <= 1'b1;
            end
          end
        end
        // Leave unconditionally so the frozen instruction is never issued twice.
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
